apu_pll_sequencer: RTL and testbench

//  Sequences the APU clock PLL (50 MHz ref -> 24.75 MHz): drives the PLL reset, qualifies its

---
 rtl/apu_pll_seq_pkg.sv | 21 ++
 rtl/apu_pll_seq_sync_2ff.sv | 23 ++
 rtl/apu_pll_sequencer.sv | 152 +++++++++++++++
 tb/tb_apu_pll_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_pll_seq_pkg.sv
// Shared state encodings and counter sizing helper for the APU PLL sequencer.
package apu_pll_seq_pkg;

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_WAIT   = 3'd1,
      S_STABLE = 3'd2,
      S_RUN    = 3'd3,
      S_FAULT  = 3'd4
   } state_t;

   // Bits needed to count 0..max-1 of the three phase lengths; never below 1.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/apu_pll_seq_sync_2ff.sv
// Generic two-flop synchroniser; output clears to 0 on reset.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_reg <= '0;
         q        <= '0;
      end else begin
         meta_reg <= d;
         q        <= meta_reg;
      end
   end

endmodule

// File: rtl/apu_pll_sequencer.sv
// Sequences the APU PLL: holds it in reset, qualifies lock, then releases the APU reset request.
module apu_pll_sequencer
   import apu_pll_seq_pkg::*;
#(
   parameter int RESET_CYCLES  = 16,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 3
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       restart,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       apu_rst,
   output logic       running,
   output logic       fault,
   output logic       lock_lost,
   output logic [7:0] lost_count,
   output logic [2:0] state
);

   localparam int CW = cnt_width(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
   localparam int RW = $clog2(MAX_RETRIES + 1);

   localparam logic [CW-1:0] RESET_LAST  = CW'(RESET_CYCLES - 1);
   localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRIES - 1);

   logic          lock_s;
   state_t        state_reg;
   state_t        state_next;
   logic [CW-1:0] cnt_reg;
   logic [RW-1:0] retry_reg;
   logic          cnt_clr;
   logic          cnt_en;
   logic          retry_inc;
   logic          retry_clr;
   logic          lost_evt;

   sync_2ff #(
      .WIDTH(1)
   ) u_lock_sync (
      .clk  (refclk),
      .rst_n(rst_n),
      .d    (pll_locked),
      .q    (lock_s)
   );

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) state_reg <= S_RESET;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      cnt_clr    = 1'b0;
      cnt_en     = 1'b0;
      retry_inc  = 1'b0;
      retry_clr  = 1'b0;
      lost_evt   = 1'b0;
      if (restart) begin
         // Restart wins everywhere and deliberately suppresses the lock_lost pulse.
         state_next = S_RESET;
         cnt_clr    = 1'b1;
         retry_clr  = 1'b1;
      end else begin
         case (state_reg)
            S_RESET: begin
               cnt_en = 1'b1;
               if (cnt_reg == RESET_LAST) begin
                  state_next = S_WAIT;
                  cnt_clr    = 1'b1;
               end
            end
            S_WAIT: begin
               cnt_en = 1'b1;
               if (lock_s) begin
                  state_next = S_STABLE;
                  cnt_clr    = 1'b1;
               end else if (cnt_reg == LOCK_LAST) begin
                  cnt_clr    = 1'b1;
                  retry_inc  = 1'b1;
                  state_next = (retry_reg == RETRY_LAST) ? S_FAULT : S_RESET;
               end
            end
            S_STABLE: begin
               cnt_en = 1'b1;
               if (!lock_s) begin
                  state_next = S_WAIT;
                  cnt_clr    = 1'b1;
               end else if (cnt_reg == STABLE_LAST) begin
                  state_next = S_RUN;
                  cnt_clr    = 1'b1;
                  retry_clr  = 1'b1;
               end
            end
            S_RUN: begin
               if (!lock_s) begin
                  state_next = S_RESET;
                  cnt_clr    = 1'b1;
                  lost_evt   = 1'b1;
               end
            end
            S_FAULT: begin
               cnt_clr = 1'b1;
            end
            default: begin
               state_next = S_RESET;
               cnt_clr    = 1'b1;
               retry_clr  = 1'b1;
            end
         endcase
      end
   end

   // Counter is frozen in RUN and FAULT so it can never wrap.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg   <= '0;
         retry_reg <= '0;
      end else begin
         if (cnt_clr)     cnt_reg <= '0;
         else if (cnt_en) cnt_reg <= cnt_reg + CW'(1);
         if (retry_clr)      retry_reg <= '0;
         else if (retry_inc) retry_reg <= retry_reg + RW'(1);
      end
   end

   // Outputs decode the next state so they change on the same edge as the state.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         pll_rst    <= 1'b1;
         apu_rst    <= 1'b1;
         running    <= 1'b0;
         fault      <= 1'b0;
         lock_lost  <= 1'b0;
         lost_count <= 8'd0;
      end else begin
         pll_rst   <= (state_next == S_RESET) || (state_next == S_FAULT);
         apu_rst   <= (state_next != S_RUN);
         running   <= (state_next == S_RUN);
         fault     <= (state_next == S_FAULT);
         lock_lost <= lost_evt;
         if (lost_evt && (lost_count != 8'hFF)) lost_count <= lost_count + 8'd1;
      end
   end

   assign state = state_reg;

endmodule

// File: tb/tb_apu_pll_sequencer.sv
// Directed self-checking bench for apu_pll_sequencer with short phase lengths.
module tb_apu_pll_sequencer;

   logic       refclk;
   logic       rst_n;
   logic       restart;
   logic       pll_locked;
   logic       pll_rst;
   logic       apu_rst;
   logic       running;
   logic       fault;
   logic       lock_lost;
   logic [7:0] lost_count;
   logic [2:0] state;

   int checks;
   int errors;

   localparam logic [14:0] RST_VEC = {5'b11000, 8'd0, 3'd0};
   logic [14:0] out_vec;
   assign out_vec = {pll_rst, apu_rst, running, fault, lock_lost, lost_count, state};

   apu_pll_sequencer #(
      .RESET_CYCLES (4),
      .LOCK_TIMEOUT (20),
      .STABLE_CYCLES(8),
      .MAX_RETRIES  (2)
   ) dut (
      .refclk    (refclk),
      .rst_n     (rst_n),
      .restart   (restart),
      .pll_locked(pll_locked),
      .pll_rst   (pll_rst),
      .apu_rst   (apu_rst),
      .running   (running),
      .fault     (fault),
      .lock_lost (lock_lost),
      .lost_count(lost_count),
      .state     (state)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge refclk);
      #1;
   endtask

   task automatic do_reset(input logic lock);
      rst_n      = 1'b0;
      restart    = 1'b0;
      pll_locked = lock;
      step(2);
      rst_n = 1'b1;
   endtask

   task automatic wait_running(input string name);
      for (int i = 0; i < 100 && !running; i++) step(1);
      checks++;
      if (running !== 1'b1) begin
         errors++;
         $display("FAIL %s timeout waiting for running: running=%b state=%0d", name, running, state);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; restart = 1'b0; pll_locked = 1'b0;
      step(2);
      checks++;
      if (out_vec !== RST_VEC) begin
         errors++;
         $display("FAIL reset_values got=%h want=%h", out_vec, RST_VEC);
      end
      $display("test_reset: outputs=%h", out_vec);
   endtask

   task automatic test_nominal;
      do_reset(1'b0);
      step(3);
      checks++;
      if ({pll_rst, state} !== {1'b1, 3'd0}) begin
         errors++;
         $display("FAIL nominal_reset_hold pll_rst=%b state=%0d want 1/0", pll_rst, state);
      end
      step(1);
      checks++;
      if ({pll_rst, apu_rst, state} !== {1'b0, 1'b1, 3'd1}) begin
         errors++;
         $display("FAIL nominal_wait pll_rst=%b apu_rst=%b state=%0d want 0/1/1", pll_rst, apu_rst, state);
      end
      step(6);
      pll_locked = 1'b1;
      // Lock sample lands in WAIT 3 edges after the rise, then 8 edges in STABLE.
      step(10);
      checks++;
      if ({running, state} !== {1'b0, 3'd2}) begin
         errors++;
         $display("FAIL nominal_stable running=%b state=%0d want 0/2", running, state);
      end
      step(1);
      checks++;
      if ({running, apu_rst, pll_rst, fault, state} !== {4'b1000, 3'd3}) begin
         errors++;
         $display("FAIL nominal_run run/apu/pll/fault=%b%b%b%b state=%0d want 1000/3",
                  running, apu_rst, pll_rst, fault, state);
      end
      $display("test_nominal: state=%0d running=%b", state, running);
   endtask

   task automatic test_restart;
      restart = 1'b1; step(1); restart = 1'b0;
      checks++;
      if ({state, lock_lost, lost_count, apu_rst, running} !== {3'd0, 1'b0, 8'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL restart_run state=%0d lock_lost=%b lost_count=%0d apu_rst=%b running=%b want 0/0/0/1/0",
                  state, lock_lost, lost_count, apu_rst, running);
      end
      step(8);
      checks++;
      if (state !== 3'd2) begin
         errors++;
         $display("FAIL restart_reach_stable state=%0d want 2", state);
      end
      restart = 1'b1; step(1); restart = 1'b0;
      checks++;
      if ({state, lock_lost, lost_count} !== {3'd0, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL restart_stable state=%0d lock_lost=%b lost_count=%0d want 0/0/0", state, lock_lost, lost_count);
      end
      restart = 1'b1; step(10); restart = 1'b0;
      step(3);
      checks++;
      if (state !== 3'd0) begin
         errors++;
         $display("FAIL restart_held_count state=%0d want 0", state);
      end
      step(1);
      checks++;
      if (state !== 3'd1) begin
         errors++;
         $display("FAIL restart_held_exit state=%0d want 1", state);
      end
      $display("test_restart: state=%0d lost_count=%0d", state, lost_count);
   endtask

   task automatic test_timeout_fault;
      do_reset(1'b0);
      step(24);
      checks++;
      if ({state, pll_rst, fault} !== {3'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL timeout_retry1 state=%0d pll_rst=%b fault=%b want 0/1/0", state, pll_rst, fault);
      end
      step(23);
      checks++;
      if ({state, fault} !== {3'd1, 1'b0}) begin
         errors++;
         $display("FAIL timeout_last_wait state=%0d fault=%b want 1/0", state, fault);
      end
      step(1);
      checks++;
      if ({state, fault, pll_rst, apu_rst} !== {3'd4, 3'b111}) begin
         errors++;
         $display("FAIL timeout_fault state=%0d fault/pll/apu=%b%b%b want 4/111", state, fault, pll_rst, apu_rst);
      end
      step(1000);
      checks++;
      if ({state, fault} !== {3'd4, 1'b1}) begin
         errors++;
         $display("FAIL fault_sticky state=%0d fault=%b want 4/1", state, fault);
      end
      restart = 1'b1; step(1); restart = 1'b0;
      checks++;
      if ({state, fault, pll_rst} !== {3'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL fault_restart state=%0d fault=%b pll_rst=%b want 0/0/1", state, fault, pll_rst);
      end
      // One timeout after restart must retry, not fault: retries were cleared.
      step(24);
      checks++;
      if ({state, fault} !== {3'd0, 1'b0}) begin
         errors++;
         $display("FAIL restart_clears_retries state=%0d fault=%b want 0/0", state, fault);
      end
      $display("test_timeout_fault: state=%0d fault=%b", state, fault);
   endtask

   task automatic test_unstable;
      do_reset(1'b0);
      step(4);
      pll_locked = 1'b1; step(5);
      pll_locked = 1'b0; step(1);
      pll_locked = 1'b1; step(1);
      checks++;
      if (state !== 3'd2) begin
         errors++;
         $display("FAIL unstable_in_stable state=%0d want 2", state);
      end
      step(1);
      checks++;
      if ({state, pll_rst} !== {3'd1, 1'b0}) begin
         errors++;
         $display("FAIL unstable_back_to_wait state=%0d pll_rst=%b want 1/0", state, pll_rst);
      end
      step(8);
      checks++;
      if ({state, running} !== {3'd2, 1'b0}) begin
         errors++;
         $display("FAIL unstable_restable state=%0d running=%b want 2/0", state, running);
      end
      step(1);
      checks++;
      if ({state, running} !== {3'd3, 1'b1}) begin
         errors++;
         $display("FAIL unstable_run state=%0d running=%b want 3/1", state, running);
      end
      $display("test_unstable: state=%0d running=%b", state, running);
   endtask

   task automatic test_lock_loss;
      int exp_count;
      pll_locked = 1'b0;
      step(2);
      checks++;
      if ({apu_rst, lock_lost, running} !== 3'b001) begin
         errors++;
         $display("FAIL loss_sync_delay apu/lost/run=%b%b%b want 001", apu_rst, lock_lost, running);
      end
      step(1);
      checks++;
      if ({apu_rst, lock_lost, running, lost_count, state} !== {3'b110, 8'd1, 3'd0}) begin
         errors++;
         $display("FAIL loss_detect apu/lost/run=%b%b%b lost_count=%0d state=%0d want 110/1/0",
                  apu_rst, lock_lost, running, lost_count, state);
      end
      pll_locked = 1'b1;
      step(1);
      checks++;
      if (lock_lost !== 1'b0) begin
         errors++;
         $display("FAIL loss_pulse_width lock_lost=%b want 0", lock_lost);
      end
      wait_running("loss_resequence");
      for (int n = 2; n <= 300; n++) begin
         pll_locked = 1'b0;
         step(3);
         exp_count = (n > 255) ? 255 : n;
         checks++;
         if ({lock_lost, lost_count} !== {1'b1, 8'(exp_count)}) begin
            errors++;
            $display("FAIL loss_repeat_%0d lock_lost=%b lost_count=%0d want 1/%0d", n, lock_lost, lost_count, exp_count);
         end
         pll_locked = 1'b1;
         wait_running("loss_repeat_resequence");
      end
      $display("test_lock_loss: lost_count=%0d", lost_count);
   endtask

   task automatic test_async_reset;
      restart = 1'b1; step(1); restart = 1'b0;
      step(7);
      checks++;
      if (state !== 3'd2) begin
         errors++;
         $display("FAIL async_setup_stable state=%0d want 2", state);
      end
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (out_vec !== RST_VEC) begin
         errors++;
         $display("FAIL async_reset_stable got=%h want=%h", out_vec, RST_VEC);
      end
      pll_locked = 1'b0;
      step(1);
      rst_n = 1'b1;
      for (int i = 0; i < 100 && !fault; i++) step(1);
      checks++;
      if ({fault, state} !== {1'b1, 3'd4}) begin
         errors++;
         $display("FAIL async_setup_fault fault=%b state=%0d want 1/4", fault, state);
      end
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (out_vec !== RST_VEC) begin
         errors++;
         $display("FAIL async_reset_fault got=%h want=%h", out_vec, RST_VEC);
      end
      step(1);
      rst_n = 1'b1;
      $display("test_async_reset: outputs=%h", out_vec);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0; restart = 1'b0; pll_locked = 1'b0;
      test_reset();
      test_nominal();
      test_restart();
      test_timeout_fault();
      test_unstable();
      test_lock_loss();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
